game_setup_ctrl: RTL and testbench

- Parametrised setup and idle controller for the Simon (Genius) game.
- Validates and latches player configuration (mode, level, speed) and derives the target sequence length from a parametrised formula.
- Runs a start/done handshake with the game core and drops into an attract state after configurable inactivity.
- Sits between the settings front-end (switch debouncers) and the game sequencer/core.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/game_setup_ctrl_inactivity_timer.sv | 34 +++
 rtl/game_setup_ctrl.sv | 155 +++++++++++++++
 tb/tb_game_setup_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the Simon game setup/idle control path.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONFIG  = 3'd1,
    S_READY   = 3'd2,
    S_RUN     = 3'd3,
    S_ATTRACT = 3'd4
  } state_t;

  localparam int unsigned DEF_RESERVED_MODE = 3;
  localparam int unsigned DEF_BASE_LEN      = 8;
  localparam int unsigned DEF_LEN_STEP      = 8;

  // Sequence length = base + level*step, wrapped to seq_w+level_w+1 bits, then
  // saturated to the largest value representable in seq_w bits.
  function automatic int unsigned calc_seq_len(
    input int unsigned base,
    input int unsigned step,
    input int unsigned level,
    input int unsigned seq_w,
    input int unsigned level_w
  );
    longint unsigned calc_mask;
    longint unsigned sat_val;
    longint unsigned raw;
    calc_mask = (64'd1 << (seq_w + level_w + 32'd1)) - 64'd1;
    sat_val   = (64'd1 << seq_w) - 64'd1;
    raw       = (64'(base) + 64'(level) * 64'(step)) & calc_mask;
    return (raw > sat_val) ? 32'(sat_val) : 32'(raw);
  endfunction

  function automatic logic cfg_valid(
    input int unsigned mode,
    input int unsigned level,
    input int unsigned reserved_mode,
    input int unsigned max_level
  );
    return (mode != reserved_mode) && (level <= max_level);
  endfunction

endpackage

// File: rtl/game_setup_ctrl_inactivity_timer.sv
// Clearable up-counter flagging the last cycle before a programmable timeout.
module inactivity_timer #(
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned TERMINAL = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // TERMINAL of zero means the timeout never fires.
  generate
    if (TERMINAL == 0) begin : g_no_tc
      assign o_tc_c = 1'b0;
    end else begin : g_tc
      assign o_tc_c = (count == WIDTH'(TERMINAL - 1));
    end
  endgenerate

endmodule

// File: rtl/game_setup_ctrl.sv
// Setup/idle controller: validates and latches player config, derives sequence
// length, runs the start/done handshake and falls into attract when idle.
module game_setup_ctrl
  import game_pkg::*;
#(
  parameter int unsigned MODE_W         = 2,
  parameter int unsigned LEVEL_W        = 2,
  parameter int unsigned SPEED_W        = 2,
  parameter int unsigned SEQ_LEN_W      = 6,
  parameter int unsigned BASE_LEN       = DEF_BASE_LEN,
  parameter int unsigned LEN_STEP       = DEF_LEN_STEP,
  parameter int unsigned MAX_LEVEL      = 3,
  parameter int unsigned RESERVED_MODE  = DEF_RESERVED_MODE,
  parameter int unsigned ATTRACT_CYCLES = 1000000,
  parameter int unsigned TMR_W          = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [MODE_W-1:0]    i_mode,
  input  logic [LEVEL_W-1:0]   i_level,
  input  logic [SPEED_W-1:0]   i_speed,
  input  logic                 i_cfg_valid,
  input  logic                 i_start_req,
  input  logic                 i_game_done,
  output logic [MODE_W-1:0]    o_mode,
  output logic [LEVEL_W-1:0]   o_level,
  output logic [SPEED_W-1:0]   o_speed,
  output logic [SEQ_LEN_W-1:0] o_seq_len,
  output logic                 o_cfg_err,
  output logic                 o_start,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_attract,
  output logic                 o_active
);

  localparam int unsigned RESET_LEN =
    calc_seq_len(BASE_LEN, LEN_STEP, 0, SEQ_LEN_W, LEVEL_W);

  state_t               state;
  state_t               state_n;
  logic                 cfg_ok_c;
  logic                 latch_c;
  logic                 err_c;
  logic                 start_c;
  logic                 tmr_clear_c;
  logic                 tmr_en_c;
  logic                 tmr_tc_c;
  logic [SEQ_LEN_W-1:0] len_c;

  assign cfg_ok_c = cfg_valid(32'(i_mode), 32'(i_level), RESERVED_MODE, MAX_LEVEL);
  assign len_c    = SEQ_LEN_W'(calc_seq_len(BASE_LEN, LEN_STEP, 32'(i_level),
                                            SEQ_LEN_W, LEVEL_W));

  // Inactivity only accumulates while waiting for a config in CONFIG.
  assign tmr_en_c    = (state == S_CONFIG) && !i_cfg_valid;
  assign tmr_clear_c = !i_enable || (state != S_CONFIG) || i_cfg_valid;

  inactivity_timer #(
    .WIDTH    (TMR_W),
    .TERMINAL (ATTRACT_CYCLES)
  ) u_attract_tmr (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (tmr_clear_c),
    .i_enable (tmr_en_c),
    .o_tc_c   (tmr_tc_c)
  );

  // Next state plus latch/pulse decisions; enable low overrides everything.
  always_comb begin
    state_n = state;
    latch_c = 1'b0;
    err_c   = 1'b0;
    start_c = 1'b0;
    if (!i_enable) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_CONFIG;
        end
        S_CONFIG: begin
          if (i_cfg_valid) begin
            if (cfg_ok_c) begin
              latch_c = 1'b1;
              state_n = S_READY;
            end else begin
              err_c = 1'b1;
            end
          end else if (tmr_tc_c) begin
            state_n = S_ATTRACT;
          end
        end
        S_READY: begin
          if (i_cfg_valid) begin
            latch_c = cfg_ok_c;
            err_c   = !cfg_ok_c;
          end
          // Starting wins over an error report so the two pulses stay exclusive.
          if (i_start_req) begin
            err_c   = 1'b0;
            start_c = 1'b1;
            state_n = S_RUN;
          end
        end
        S_RUN: begin
          if (i_game_done) begin
            state_n = S_READY;
          end
        end
        S_ATTRACT: begin
          if (i_cfg_valid || i_start_req) begin
            state_n = S_CONFIG;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      o_mode    <= '0;
      o_level   <= '0;
      o_speed   <= '0;
      o_seq_len <= SEQ_LEN_W'(RESET_LEN);
      o_cfg_err <= 1'b0;
      o_start   <= 1'b0;
      o_ready   <= 1'b0;
      o_busy    <= 1'b0;
      o_attract <= 1'b0;
      o_active  <= 1'b0;
    end else begin
      state <= state_n;
      if (latch_c) begin
        o_mode    <= i_mode;
        o_level   <= i_level;
        o_speed   <= i_speed;
        o_seq_len <= len_c;
      end
      o_cfg_err <= err_c;
      o_start   <= start_c;
      o_ready   <= (state_n == S_READY);
      o_busy    <= (state_n == S_RUN);
      o_attract <= (state_n == S_ATTRACT);
      o_active  <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_game_setup_ctrl.sv
// Directed bench for game_setup_ctrl: a short-attract instance and a narrow
// saturating instance share the same stimulus.
module tb_game_setup_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [1:0] level;
  logic [1:0] speed;
  logic       cfg_valid;
  logic       start_req;
  logic       game_done;

  logic [1:0] o_mode, o_level, o_speed;
  logic [5:0] o_seq_len;
  logic       o_cfg_err, o_start, o_ready, o_busy, o_attract, o_active;

  logic [1:0] s_mode, s_level, s_speed;
  logic [3:0] s_seq_len;
  logic       s_cfg_err, s_start, s_ready, s_busy, s_attract, s_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_setup_ctrl #(.ATTRACT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_level(level),
    .i_speed(speed), .i_cfg_valid(cfg_valid), .i_start_req(start_req),
    .i_game_done(game_done), .o_mode(o_mode), .o_level(o_level), .o_speed(o_speed),
    .o_seq_len(o_seq_len), .o_cfg_err(o_cfg_err), .o_start(o_start),
    .o_ready(o_ready), .o_busy(o_busy), .o_attract(o_attract), .o_active(o_active)
  );

  game_setup_ctrl #(.SEQ_LEN_W(4), .ATTRACT_CYCLES(0)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_level(level),
    .i_speed(speed), .i_cfg_valid(cfg_valid), .i_start_req(start_req),
    .i_game_done(game_done), .o_mode(s_mode), .o_level(s_level), .o_speed(s_speed),
    .o_seq_len(s_seq_len), .o_cfg_err(s_cfg_err), .o_start(s_start),
    .o_ready(s_ready), .o_busy(s_busy), .o_attract(s_attract), .o_active(s_active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = '0; level = '0; speed = '0;
    cfg_valid = 1'b0; start_req = 1'b0; game_done = 1'b0;
    step();
    step();
    checks++;
    if ({o_ready, o_busy, o_attract, o_active, o_start, o_cfg_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
                         {o_ready, o_busy, o_attract, o_active, o_start, o_cfg_err});
    end
    checks++;
    if (o_seq_len !== 6'd8 || o_mode !== 2'd0) begin
      errors++; $display("FAIL reset_cfg: seq_len %0d mode %0d expected 8 0", o_seq_len, o_mode);
    end
    checks++;
    if (s_seq_len !== 4'd8) begin
      errors++; $display("FAIL reset_sat_len: got %0d expected 8", s_seq_len);
    end
    rst = 1'b0;
  endtask

  task automatic test_cfg_err();
    en = 1'b1;
    step();
    checks++;
    if (o_active !== 1'b1 || o_ready !== 1'b0) begin
      errors++; $display("FAIL enter_config: active %b ready %b expected 1 0", o_active, o_ready);
    end
    mode = 2'd3; level = 2'd1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (o_cfg_err !== 1'b1 || o_ready !== 1'b0 || o_active !== 1'b1) begin
      errors++; $display("FAIL cfg_err_pulse: err %b ready %b active %b expected 1 0 1",
                         o_cfg_err, o_ready, o_active);
    end
    checks++;
    if (o_mode !== 2'd0 || o_seq_len !== 6'd8) begin
      errors++; $display("FAIL cfg_err_keep: mode %0d seq_len %0d expected 0 8", o_mode, o_seq_len);
    end
    step();
    checks++;
    if (o_cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfg_err_width: got %b expected 0", o_cfg_err);
    end
  endtask

  task automatic test_config_valid();
    mode = 2'd1; level = 2'd2; speed = 2'd2; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_active !== 1'b1 || o_cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfg_ready: ready %b active %b err %b expected 1 1 0",
                         o_ready, o_active, o_cfg_err);
    end
    checks++;
    if (o_seq_len !== 6'd24 || o_mode !== 2'd1 || o_level !== 2'd2 || o_speed !== 2'd2) begin
      errors++; $display("FAIL cfg_latch: len %0d mode %0d level %0d speed %0d expected 24 1 2 2",
                         o_seq_len, o_mode, o_level, o_speed);
    end
    checks++;
    if (s_seq_len !== 4'd15) begin
      errors++; $display("FAIL sat_level2: got %0d expected 15", s_seq_len);
    end
  endtask

  task automatic test_ready_reconfig();
    mode = 2'd2; level = 2'd0; speed = 2'd1; cfg_valid = 1'b1;
    step();
    checks++;
    if (o_ready !== 1'b1 || o_seq_len !== 6'd8 || o_mode !== 2'd2 || o_cfg_err !== 1'b0) begin
      errors++; $display("FAIL ready_relatch: ready %b len %0d mode %0d err %b expected 1 8 2 0",
                         o_ready, o_seq_len, o_mode, o_cfg_err);
    end
    mode = 2'd3; level = 2'd3;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (o_cfg_err !== 1'b1 || o_seq_len !== 6'd8 || o_mode !== 2'd2 || o_ready !== 1'b1) begin
      errors++; $display("FAIL ready_bad_cfg: err %b len %0d mode %0d ready %b expected 1 8 2 1",
                         o_cfg_err, o_seq_len, o_mode, o_ready);
    end
  endtask

  task automatic test_run();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    checks++;
    if (o_start !== 1'b1 || o_busy !== 1'b1 || o_ready !== 1'b0 || o_cfg_err !== 1'b0) begin
      errors++; $display("FAIL run_start: start %b busy %b ready %b err %b expected 1 1 0 0",
                         o_start, o_busy, o_ready, o_cfg_err);
    end
    step();
    checks++;
    if (o_start !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL run_start_width: start %b busy %b expected 0 1", o_start, o_busy);
    end
    start_req = 1'b1; cfg_valid = 1'b1; mode = 2'd1; level = 2'd3;
    step();
    start_req = 1'b0; cfg_valid = 1'b0;
    checks++;
    if (o_start !== 1'b0 || o_seq_len !== 6'd8 || o_mode !== 2'd2 || o_busy !== 1'b1) begin
      errors++; $display("FAIL run_ignore: start %b len %0d mode %0d busy %b expected 0 8 2 1",
                         o_start, o_seq_len, o_mode, o_busy);
    end
    step();
    step();
    game_done = 1'b1;
    step();
    game_done = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_seq_len !== 6'd8 || o_mode !== 2'd2) begin
      errors++; $display("FAIL run_done: ready %b busy %b len %0d mode %0d expected 1 0 8 2",
                         o_ready, o_busy, o_seq_len, o_mode);
    end
  endtask

  task automatic test_back_to_back();
    start_req = 1'b1; cfg_valid = 1'b1; mode = 2'd1; level = 2'd1; speed = 2'd3;
    step();
    start_req = 1'b0; cfg_valid = 1'b0;
    checks++;
    if (o_start !== 1'b1 || o_seq_len !== 6'd16 || o_mode !== 2'd1 || o_speed !== 2'd3) begin
      errors++; $display("FAIL start_new_cfg: start %b len %0d mode %0d speed %0d expected 1 16 1 3",
                         o_start, o_seq_len, o_mode, o_speed);
    end
    checks++;
    if (s_seq_len !== 4'd15 || s_start !== 1'b1) begin
      errors++; $display("FAIL sat_level1: len %0d start %b expected 15 1", s_seq_len, s_start);
    end
    game_done = 1'b1;
    step();
    game_done = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_start !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL done_with_start: ready %b start %b busy %b expected 1 0 0",
                         o_ready, o_start, o_busy);
    end
  endtask

  task automatic test_attract();
    en = 1'b0;
    step();
    checks++;
    if (o_active !== 1'b0 || o_ready !== 1'b0 || o_mode !== 2'd1 || o_seq_len !== 6'd16) begin
      errors++; $display("FAIL disable_idle: active %b ready %b mode %0d len %0d expected 0 0 1 16",
                         o_active, o_ready, o_mode, o_seq_len);
    end
    en = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (o_attract !== 1'b0 || o_active !== 1'b1) begin
      errors++; $display("FAIL attract_early: attract %b active %b expected 0 1", o_attract, o_active);
    end
    step();
    checks++;
    if (o_attract !== 1'b1 || o_active !== 1'b1) begin
      errors++; $display("FAIL attract_enter: attract %b active %b expected 1 1", o_attract, o_active);
    end
    checks++;
    if (s_attract !== 1'b0 || s_active !== 1'b1) begin
      errors++; $display("FAIL attract_disabled: attract %b active %b expected 0 1", s_attract, s_active);
    end
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    checks++;
    if (o_attract !== 1'b0 || o_active !== 1'b1 || o_start !== 1'b0 || o_ready !== 1'b0) begin
      errors++; $display("FAIL attract_exit: attract %b active %b start %b ready %b expected 0 1 0 0",
                         o_attract, o_active, o_start, o_ready);
    end
  endtask

  task automatic test_enable_low_run();
    cfg_valid = 1'b1; mode = 2'd0; level = 2'd0;
    step();
    cfg_valid = 1'b0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL pre_disable_busy: got %b expected 1", o_busy);
    end
    en = 1'b0;
    step();
    checks++;
    if (o_busy !== 1'b0 || o_active !== 1'b0 || o_ready !== 1'b0 || o_mode !== 2'd0 ||
        o_seq_len !== 6'd8) begin
      errors++; $display("FAIL disable_run: busy %b active %b ready %b mode %0d len %0d expected 0 0 0 0 8",
                         o_busy, o_active, o_ready, o_mode, o_seq_len);
    end
  endtask

  task automatic test_reset_run();
    en = 1'b1;
    step();
    cfg_valid = 1'b1; mode = 2'd2; level = 2'd3; speed = 2'd1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (o_seq_len !== 6'd32 || o_ready !== 1'b1) begin
      errors++; $display("FAIL level3_len: len %0d ready %b expected 32 1", o_seq_len, o_ready);
    end
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    rst = 1'b1; start_req = 1'b1; cfg_valid = 1'b1; mode = 2'd3;
    step();
    rst = 1'b0; start_req = 1'b0; cfg_valid = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_attract, o_active, o_start, o_cfg_err} !== 6'b0) begin
      errors++; $display("FAIL reset_run_flags: got %b expected 000000",
                         {o_ready, o_busy, o_attract, o_active, o_start, o_cfg_err});
    end
    checks++;
    if (o_mode !== 2'd0 || o_level !== 2'd0 || o_speed !== 2'd0 || o_seq_len !== 6'd8) begin
      errors++; $display("FAIL reset_run_cfg: mode %0d level %0d speed %0d len %0d expected 0 0 0 8",
                         o_mode, o_level, o_speed, o_seq_len);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_err();
    test_config_valid();
    test_ready_reconfig();
    test_run();
    test_back_to_back();
    test_attract();
    test_enable_low_run();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
